// File: rtl/sparc_ifu_repl_sel.sv
`default_nettype none
// ============================================================================
// Module   : sparc_ifu_repl_sel
// Brief    : Icache fill-way selector with an in-order outstanding-fill queue.
// Revision : 1.0
// ============================================================================
module sparc_ifu_repl_sel #(
  parameter int SETW  = 7,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            miss_vld,
  output logic            miss_rdy,
  input  logic [SETW-1:0] miss_set,
  input  logic [3:0]      miss_wayvld,
  input  logic [1:0]      lfsr_out,
  output logic            lfsr_advance,
  output logic            sel_vld,
  output logic [1:0]      sel_way,
  output logic            fill_vld,
  output logic [1:0]      fill_way,
  output logic [SETW-1:0] fill_set,
  input  logic            fill_done
);

  localparam int c_ptrw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cntw = $clog2(DEPTH + 1);
  localparam logic [c_ptrw-1:0] c_last_ptr = c_ptrw'(DEPTH - 1);
  localparam logic [c_cntw-1:0] c_full_cnt = c_cntw'(DEPTH);

  logic [c_cntw-1:0] r_count;
  logic [c_ptrw-1:0] r_wrptr;
  logic [c_ptrw-1:0] r_rdptr;
  logic [DEPTH-1:0]  r_q_vld;
  logic [SETW-1:0]   r_q_set [DEPTH];
  logic [1:0]        r_q_way [DEPTH];
  logic              r_sel_vld;
  logic [1:0]        r_sel_way;

  logic              w_accept;
  logic              w_pop;
  logic [3:0]        w_pm;
  logic [3:0]        w_cand;
  logic [3:0]        w_inv;
  logic              w_inv_any;
  logic [1:0]        w_inv_way;
  logic [1:0]        w_rnd_way;
  logic [1:0]        w_try;
  logic              w_found;
  logic [1:0]        w_way;

  function automatic logic [c_ptrw-1:0] ptr_inc(input logic [c_ptrw-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Reset gates accept so the LFSR never steps while reset is held.
  assign miss_rdy = (r_count != c_full_cnt);
  assign w_accept = miss_vld & miss_rdy & ~reset;
  assign fill_vld = (r_count != '0);
  assign w_pop    = fill_done & fill_vld;

  always_comb begin
    w_pm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_vld[i] && (r_q_set[i] == miss_set)) begin
        w_pm[r_q_way[i]] = 1'b1;
      end
    end
  end

  assign w_cand    = ~w_pm;
  assign w_inv     = w_cand & ~miss_wayvld;
  assign w_inv_any = |w_inv;

  always_comb begin
    w_inv_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (w_inv[w]) begin
        w_inv_way = 2'(w);
      end
    end
  end

  // Walk forward from the LFSR value; at most DEPTH-1 ways can be pending.
  always_comb begin
    w_rnd_way = lfsr_out;
    w_found   = 1'b0;
    w_try     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_try = lfsr_out + 2'(k);
      if (!w_found && w_cand[w_try]) begin
        w_rnd_way = w_try;
        w_found   = 1'b1;
      end
    end
  end

  assign w_way        = w_inv_any ? w_inv_way : w_rnd_way;
  assign lfsr_advance = w_accept & ~w_inv_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_vld <= 1'b0;
      r_sel_way <= 2'd0;
    end else begin
      r_sel_vld <= w_accept;
      if (w_accept) begin
        r_sel_way <= w_way;
      end
    end
  end

  assign sel_vld = r_sel_vld;
  assign sel_way = r_sel_way;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_set[i] <= '0;
        r_q_way[i] <= 2'd0;
      end
    end else begin
      if (w_accept) begin
        r_q_set[r_wrptr] <= miss_set;
        r_q_way[r_wrptr] <= w_way;
        r_q_vld[r_wrptr] <= 1'b1;
        r_wrptr          <= ptr_inc(r_wrptr);
      end
      // Push never targets the head slot because the queue is not full on accept.
      if (w_pop) begin
        r_q_vld[r_rdptr] <= 1'b0;
        r_rdptr          <= ptr_inc(r_rdptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fill_way = fill_vld ? r_q_way[r_rdptr] : 2'd0;
  assign fill_set = fill_vld ? r_q_set[r_rdptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sparc_ifu_repl_sel.sv
`default_nettype none
// Directed table-driven bench for sparc_ifu_repl_sel (SETW=7, DEPTH=2).
module tb_sparc_ifu_repl_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       miss_vld;
  logic       miss_rdy;
  logic [6:0] miss_set;
  logic [3:0] miss_wayvld;
  logic [1:0] lfsr_out;
  logic       lfsr_advance;
  logic       sel_vld;
  logic [1:0] sel_way;
  logic       fill_vld;
  logic [1:0] fill_way;
  logic [6:0] fill_set;
  logic       fill_done;

  int n_checks = 0;
  int n_fail   = 0;

  sparc_ifu_repl_sel #(.SETW(7), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .miss_vld(miss_vld), .miss_rdy(miss_rdy),
    .miss_set(miss_set), .miss_wayvld(miss_wayvld), .lfsr_out(lfsr_out),
    .lfsr_advance(lfsr_advance), .sel_vld(sel_vld), .sel_way(sel_way),
    .fill_vld(fill_vld), .fill_way(fill_way), .fill_set(fill_set),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mv;
    logic [6:0] set;
    logic [3:0] wv;
    logic [1:0] lf;
    logic       fd;
    logic       e_rdy;
    logic       e_adv;
    logic       e_svld;
    logic [1:0] e_sway;
    logic       e_fvld;
    logic [1:0] e_fway;
    logic [6:0] e_fset;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic adv,
                            input logic svld, input logic [1:0] sway, input logic fvld,
                            input logic [1:0] fway, input logic [6:0] fset);
    chk({tag, ".miss_rdy"},     32'(miss_rdy),     32'(rdy));
    chk({tag, ".lfsr_advance"}, 32'(lfsr_advance), 32'(adv));
    chk({tag, ".sel_vld"},      32'(sel_vld),      32'(svld));
    chk({tag, ".sel_way"},      32'(sel_way),      32'(sway));
    chk({tag, ".fill_vld"},     32'(fill_vld),     32'(fvld));
    chk({tag, ".fill_way"},     32'(fill_way),     32'(fway));
    chk({tag, ".fill_set"},     32'(fill_set),     32'(fset));
  endtask

  task automatic drive(input logic mv, input logic [6:0] set, input logic [3:0] wv,
                       input logic [1:0] lf, input logic fd);
    miss_vld    = mv;
    miss_set    = set;
    miss_wayvld = wv;
    lfsr_out    = lf;
    fill_done   = fd;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      drive(tbl[i].mv, tbl[i].set, tbl[i].wv, tbl[i].lf, tbl[i].fd);
      #2;
      check_outs($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_adv, tbl[i].e_svld,
                 tbl[i].e_sway, tbl[i].e_fvld, tbl[i].e_fway, tbl[i].e_fset);
    end
  endtask

  initial begin
    //        mv   set    wv       lf    fd  | rdy adv svld sway fvld fway  fset
    tbl[0]  = '{1'b1, 7'd5,  4'b1011, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd0};
    tbl[1]  = '{1'b0, 7'd0,  4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 7'd5};
    tbl[2]  = '{1'b1, 7'd9,  4'b1111, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 7'd0};
    tbl[3]  = '{1'b1, 7'd9,  4'b1111, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 7'd9};
    tbl[4]  = '{1'b1, 7'd9,  4'b1111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 7'd9};
    tbl[5]  = '{1'b1, 7'd9,  4'b1111, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd1, 7'd9};
    tbl[6]  = '{1'b0, 7'd0,  4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 7'd9};
    tbl[7]  = '{1'b0, 7'd0,  4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 2'd3, 7'd27};
    tbl[8]  = '{1'b1, 7'd3,  4'b1110, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 7'd0};
    tbl[9]  = '{1'b1, 7'd3,  4'b1110, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 7'd3};
    tbl[10] = '{1'b0, 7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 7'd3};

    reset = 1'b1;
    drive(1'b0, 7'd0, 4'b0000, 2'd0, 1'b0);
    #7;
    check_outs("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd0);
    @(negedge clk);
    reset = 1'b0;

    // Invalid-way pick, random pick with pending skip, full-queue stall and pop.
    run_rows(0, 6);

    // Simultaneous push and pop at count 1; pointers wrap several times.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 7'(20 + i), ~(4'b0001 << (i % 4)), 2'(i), 1'b1);
      #2;
      if (i == 0)
        check_outs($sformatf("pushpop%0d", i), 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 7'd9);
      else
        check_outs($sformatf("pushpop%0d", i), 1'b1, 1'b0, 1'b1, 2'((i - 1) % 4),
                   1'b1, 2'((i - 1) % 4), 7'(19 + i));
    end

    // Drain, then pending way 0 on set 3 forces the random path past it.
    run_rows(7, 10);

    // Asynchronous reset mid-cycle while full with sel_vld high.
    #1;
    drive(1'b1, 7'd4, 4'b1111, 2'd1, 1'b0);
    reset = 1'b1;
    #1;
    check_outs("async_rst", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 7'd1, 4'b0000, 2'd0, 1'b0);
    #2;
    check_outs("post_rst_acc", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 7'd0);
    @(negedge clk);
    drive(1'b0, 7'd0, 4'b0000, 2'd0, 1'b0);
    #2;
    check_outs("post_rst_sel", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 7'd1);
    @(negedge clk);
    #2;
    chk("sel_pulse_one_cycle", 32'(sel_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
